// File: rtl/alu_multiword_seq.sv
// Multi-word ALU sequencer: drives a 32-bit combinational ALU one limb per cycle,
// LSB limb first, chaining carry between limbs and assembling a WORDS*32-bit result.
module alu_multiword_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cmd,
    input  logic [32*WORDS-1:0]   a_in,
    input  logic [32*WORDS-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [32*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  sign,
    output logic                  zero,
    output logic [31:0]           alu_A,
    output logic [31:0]           alu_B,
    output logic [5:0]            alu_opcode,
    output logic                  alu_CarryIn,
    input  logic [31:0]           alu_Result,
    input  logic                  alu_CarryFlag,
    input  logic                  alu_ZeroFlag,
    input  logic                  alu_OverflowFlag,
    input  logic                  alu_SignFlag
);

    localparam int unsigned W    = 32 * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);

    localparam logic [2:0] CmdAdd = 3'd0;
    localparam logic [2:0] CmdSub = 3'd1;
    localparam logic [2:0] CmdAnd = 3'd2;
    localparam logic [2:0] CmdOr  = 3'd3;
    localparam logic [2:0] CmdXor = 3'd4;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              carry_q, carry_d;
    logic              zacc_q, zacc_d;
    logic              inv_q, inv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [W-1:0]      result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              sign_q, sign_d;
    logic              zero_q, zero_d;
    logic              is_arith;
    logic              unused_sign;

    assign unused_sign = alu_SignFlag;
    assign is_arith    = (cmd_q == CmdAdd) || (cmd_q == CmdSub);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cmd_q       <= CmdAdd;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            inv_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cmd_q       <= cmd_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            inv_q       <= inv_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        cmd_d       = cmd_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        inv_d       = 1'b0;
        // An invalid command reports one cycle after acceptance, matching a 1-limb latency
        done_d      = inv_q;
        err_d       = inv_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        alu_A       = 32'd0;
        alu_B       = 32'd0;
        alu_opcode  = 6'b000000;
        alu_CarryIn = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cmd <= CmdXor) begin
                        state_d = StExec;
                        idx_d   = '0;
                        a_d     = a_in;
                        b_d     = b_in;
                        cmd_d   = cmd;
                        zacc_d  = 1'b1;
                    end else begin
                        inv_d = 1'b1;
                    end
                end
            end
            StExec: begin
                // Operand registers shift down so the current limb always sits in bits [31:0]
                alu_A = a_q[31:0];
                alu_B = (cmd_q == CmdSub) ? ~b_q[31:0] : b_q[31:0];
                unique case (cmd_q)
                    CmdAnd:  alu_opcode = 6'b000010;
                    CmdOr:   alu_opcode = 6'b000011;
                    CmdXor:  alu_opcode = 6'b000100;
                    default: alu_opcode = 6'b000000;
                endcase
                alu_CarryIn = is_arith && ((idx_q == '0) ? (cmd_q == CmdSub) : carry_q);
                a_d     = a_q >> 32;
                b_d     = b_q >> 32;
                carry_d = alu_CarryFlag;
                zacc_d  = zacc_q & alu_ZeroFlag;
                for (int i = 0; i < int'(WORDS); i++) begin
                    if (idx_q == IdxW'(i)) begin
                        result_d[32*i +: 32] = alu_Result;
                    end
                end
                if (idx_q == IdxW'(WORDS - 1)) begin
                    state_d     = StIdle;
                    idx_d       = '0;
                    done_d      = 1'b1;
                    zero_d      = zacc_q & alu_ZeroFlag;
                    sign_d      = alu_Result[31];
                    carry_out_d = is_arith & alu_CarryFlag;
                    overflow_d  = is_arith & alu_OverflowFlag;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q == StExec);
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign sign      = sign_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Bench for alu_multiword_seq: behavioural 32-bit ALU plus a 128-bit arithmetic reference model.
module tb_alu_multiword_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 32 * WORDS;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     cmd;
    logic [W-1:0]   a_in, b_in;
    logic           busy, done, err;
    logic [W-1:0]   result;
    logic           carry_out, overflow, sign, zero;
    logic [31:0]    alu_A, alu_B;
    logic [5:0]     alu_opcode;
    logic           alu_CarryIn;
    logic [31:0]    alu_Result;
    logic           alu_CarryFlag, alu_ZeroFlag, alu_OverflowFlag, alu_SignFlag;

    alu_multiword_seq #(.WORDS(WORDS)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cmd              (cmd),
        .a_in             (a_in),
        .b_in             (b_in),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .result           (result),
        .carry_out        (carry_out),
        .overflow         (overflow),
        .sign             (sign),
        .zero             (zero),
        .alu_A            (alu_A),
        .alu_B            (alu_B),
        .alu_opcode       (alu_opcode),
        .alu_CarryIn      (alu_CarryIn),
        .alu_Result       (alu_Result),
        .alu_CarryFlag    (alu_CarryFlag),
        .alu_ZeroFlag     (alu_ZeroFlag),
        .alu_OverflowFlag (alu_OverflowFlag),
        .alu_SignFlag     (alu_SignFlag)
    );

    always #5 clk = ~clk;

    // Downstream combinational ALU
    logic [32:0] sum33;
    always_comb begin
        sum33            = 33'd0;
        alu_Result       = 32'd0;
        alu_CarryFlag    = 1'b0;
        alu_OverflowFlag = 1'b0;
        case (alu_opcode)
            6'b000000: begin
                sum33            = {1'b0, alu_A} + {1'b0, alu_B} + {32'd0, alu_CarryIn};
                alu_Result       = sum33[31:0];
                alu_CarryFlag    = sum33[32];
                alu_OverflowFlag = (alu_A[31] == alu_B[31]) && (sum33[31] != alu_A[31]);
            end
            6'b000010: alu_Result = alu_A & alu_B;
            6'b000011: alu_Result = alu_A | alu_B;
            6'b000100: alu_Result = alu_A ^ alu_B;
            default:   alu_Result = 32'd0;
        endcase
        alu_ZeroFlag = (alu_Result == 32'd0);
        alu_SignFlag = alu_Result[31];
    end

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int k_cyc = 0;
    int busy_cycles = 0;
    int done_count = 0;
    logic cin_q[$];

    logic [W-1:0] exp_r;
    logic         exp_c, exp_v, exp_s, exp_z;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cycles <= busy_cycles + 1;
            cin_q.push_back(alu_CarryIn);
        end
        if (done === 1'b1) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: whole-operand arithmetic; invalid commands leave state unchanged
    task automatic model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        if (c > 3'd4) return;
        full  = '0;
        exp_c = 1'b0;
        exp_v = 1'b0;
        case (c)
            3'd0: begin
                full  = {1'b0, a} + {1'b0, b};
                exp_r = full[W-1:0];
                exp_c = full[W];
                exp_v = (a[W-1] == b[W-1]) && (exp_r[W-1] != a[W-1]);
            end
            3'd1: begin
                full  = {1'b0, a} + {1'b0, ~b} + 1;
                exp_r = full[W-1:0];
                exp_c = full[W];
                exp_v = (a[W-1] != b[W-1]) && (exp_r[W-1] != a[W-1]);
            end
            3'd2:    exp_r = a & b;
            3'd3:    exp_r = a | b;
            default: exp_r = a ^ b;
        endcase
        exp_s = exp_r[W-1];
        exp_z = (exp_r == '0);
    endtask

    // Call at a negedge; returns at the negedge following the accepting edge
    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        cmd   = c;
        a_in  = a;
        b_in  = b;
        k_cyc = cyc + 1;
        busy_cycles = 0;
        cin_q.delete();
        model(c, a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit exp_err);
        int guard = 0;
        while (done !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_timeout"}, W'(guard < 50), W'(1));
        check({tag, "_latency"}, W'(cyc - k_cyc), W'(exp_lat));
        check({tag, "_busy_cycles"}, W'(busy_cycles), exp_err ? W'(0) : W'(WORDS));
        check({tag, "_busy_at_done"}, W'(busy), W'(0));
        check({tag, "_err"}, W'(err), W'(exp_err));
        check({tag, "_result"}, result, exp_r);
        check({tag, "_carry"}, W'(carry_out), W'(exp_c));
        check({tag, "_ovf"}, W'(overflow), W'(exp_v));
        check({tag, "_sign"}, W'(sign), W'(exp_s));
        check({tag, "_zero"}, W'(zero), W'(exp_z));
    endtask

    logic [W-1:0] ra, rb;
    logic [2:0]   rc;
    logic [3:0]   cin_bits;
    logic [W-1:0] ones;
    logic [W-1:0] a5;

    initial begin
        ones  = '1;
        a5    = {WORDS{32'hA5A5A5A5}};
        rst   = 1'b1;
        start = 1'b0;
        cmd   = 3'd0;
        a_in  = '0;
        b_in  = '0;
        exp_r = '0;
        {exp_c, exp_v, exp_s, exp_z} = 4'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_result", result, '0);
        check("rst_flags", W'({carry_out, overflow, sign, zero}), W'(0));
        check("rst_alu_drive", W'({alu_A, alu_B, alu_opcode, alu_CarryIn}), W'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(3'd0, ones, W'(1));
        wait_done("add_wrap", WORDS, 1'b0);
        check("add_wrap_const", W'({result == '0, carry_out, zero, overflow}), W'(4'b1110));

        @(negedge clk);
        issue(3'd1, W'(5), W'(10));
        wait_done("sub_neg", WORDS, 1'b0);
        check("sub_neg_const", result, ones - W'(4));

        @(negedge clk);
        issue(3'd1, W'(16'h1234), W'(16'h1234));
        wait_done("sub_eq", WORDS, 1'b0);

        @(negedge clk);
        issue(3'd0, ones >> 1, W'(1));
        wait_done("add_ovf", WORDS, 1'b0);
        check("add_ovf_const", W'({overflow, sign}), W'(2'b11));

        @(negedge clk);
        issue(3'd4, a5, a5);
        wait_done("xor_self", WORDS, 1'b0);

        @(negedge clk);
        issue(3'd0, ones >> 32, W'(1));
        wait_done("chain", WORDS, 1'b0);
        check("chain_const", result, W'(1) << 96);
        cin_bits = '0;
        for (int i = 0; i < cin_q.size() && i < 4; i++) cin_bits = {cin_bits[2:0], cin_q[i]};
        check("chain_cin_count", W'(cin_q.size()), W'(4));
        check("chain_cin_seq", W'(cin_bits), W'(4'b0111));

        // start during limb 1 must be ignored
        @(negedge clk);
        issue(3'd0, W'(128'h1111), W'(128'h2222));
        start = 1'b1;
        cmd   = 3'd1;
        a_in  = ones;
        b_in  = W'(7);
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_start", WORDS, 1'b0);
        check("ign_start_const", result, W'(128'h3333));

        // back-to-back start in the done cycle
        issue(3'd3, {4{32'h0F0F0000}}, {4{32'h0000F0F0}});
        wait_done("b2b", WORDS, 1'b0);

        // invalid command keeps result and flags
        @(negedge clk);
        issue(3'd6, ones, ones);
        wait_done("inv", 1, 1'b1);
        @(negedge clk);
        check("inv_done_pulse", W'({done, err}), W'(0));

        for (int t = 0; t < 16; t++) begin
            rc = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = (t % 5 == 0) ? ra : {$urandom(), $urandom(), $urandom(), $urandom()};
            if (t % 7 == 3) ra = ones;
            issue(rc, ra, rb);
            wait_done("rand", (rc > 3'd4) ? 1 : int'(WORDS), rc > 3'd4);
            @(negedge clk);
            check("rand_done_pulse", W'(done), W'(0));
        end

        // reset during limb 2 aborts with no done
        issue(3'd0, ones, ones);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", W'(busy), W'(0));
        check("abort_result", result, '0);
        check("abort_flags", W'({carry_out, overflow, sign, zero}), W'(0));
        @(negedge clk);
        rst = 1'b0;
        done_count = 0;
        repeat (8) @(negedge clk);
        check("abort_no_done", W'(done_count), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
